// File: rtl/pipe_addsub_if.sv
// Handshake bundle for pipe_addsub: operand beat in, result beat out.
`timescale 1ns/1ps
interface pipe_addsub_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         ovf;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined unsigned add/subtract with valid/ready flow control and carry/borrow flag.
// Optional macro PIPE_ADDSUB_SAT_EN: saturate y on carry (all-ones) or borrow (zero).
`timescale 1ns/1ps
module pipe_addsub_chk #(
  parameter int W = 12
) (
  input logic         clk,
  input logic         rst_n,
  input logic         in_ready,
  input logic         out_valid,
  input logic         out_ready,
  input logic [W-1:0] y,
  input logic         ovf
);
  // A stalled result must stay put with its flag.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(y) && $stable(ovf)));

  // Upstream readiness is exactly the inverse of the stall.
  a_ready: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready == !(out_valid && !out_ready));
endmodule

module pipe_addsub #(
  parameter int W      = 12,
  parameter int STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave bus
);
  logic              stall_s;
  logic [W:0]        raw_s;
  logic [W-1:0]      res_y_s;
  logic              res_ovf_s;
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] ovf_r;
  logic [W-1:0]      y_r [STAGES];

  function automatic logic [W:0] add_sub(input logic [W-1:0] x, input logic [W-1:0] z,
                                         input logic sub);
    if (sub) begin
      return {1'b0, x} - {1'b0, z};
    end else begin
      return {1'b0, x} + {1'b0, z};
    end
  endfunction

  // Stage-0 result: W+1 bit arithmetic, bit W is carry (add) or borrow (sub).
  always_comb begin
    raw_s     = add_sub(bus.a, bus.b, bus.op);
    res_ovf_s = raw_s[W];
`ifdef PIPE_ADDSUB_SAT_EN
    if (raw_s[W]) begin
      res_y_s = bus.op ? {W{1'b0}} : {W{1'b1}};
    end else begin
      res_y_s = raw_s[W-1:0];
    end
`else
    res_y_s = raw_s[W-1:0];
`endif
  end

  assign stall_s      = vld_r[STAGES-1] && !bus.out_ready;
  assign bus.in_ready = !stall_s;

  // Pipeline advance; data registers only load behind a valid so idle outputs hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= {STAGES{1'b0}};
      ovf_r <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        y_r[k] <= {W{1'b0}};
      end
    end else if (!stall_s) begin
      vld_r[0] <= bus.in_valid;
      if (bus.in_valid) begin
        y_r[0]   <= res_y_s;
        ovf_r[0] <= res_ovf_s;
      end
      for (int k = 1; k < STAGES; k++) begin
        vld_r[k] <= vld_r[k-1];
        if (vld_r[k-1]) begin
          y_r[k]   <= y_r[k-1];
          ovf_r[k] <= ovf_r[k-1];
        end
      end
    end
  end

  assign bus.out_valid = vld_r[STAGES-1];
  assign bus.y         = y_r[STAGES-1];
  assign bus.ovf       = ovf_r[STAGES-1];

  pipe_addsub_chk #(.W(W)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .y         (bus.y),
    .ovf       (bus.ovf)
  );
endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter W, default 12, operand and result width in bits (legal range 2..32).
REQ-002 Parameter STAGES, default 2, pipeline latency in clock cycles (legal range 1..8).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat present on a, b, op.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  W  operand A, unsigned.
REQ-008 b  input  W  operand B, unsigned.
REQ-009 op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-010 out_valid  output  1  result present on y and ovf.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 y  output  W  result.
REQ-013 ovf  output  1  add carry-out or subtract borrow for the result on y.

Function
REQ-014 A beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-015 The stall condition SHALL be out_valid && !out_ready.
REQ-016 in_ready SHALL equal !stall, combinationally.
REQ-017 When not stalled, every pipeline stage SHALL advance by one per cycle, and the stage-0 valid SHALL load in_valid.
REQ-018 When stalled, every stage (valid, data, ovf) SHALL hold its value.
REQ-019 Bubbles SHALL NOT be collapsed.
REQ-020 With no stall, the result of a beat accepted at edge N SHALL appear on y/ovf with out_valid=1 after edge N+STAGES-1, i.e. STAGES edges after acceptance, including acceptance.
REQ-021 Arithmetic SHALL be computed at acceptance on W+1 bits:
- Add: y = (a+b) mod 2^W, ovf = bit W of the sum.
- Subtract: y = (a-b) mod 2^W, ovf = 1 iff a < b.
REQ-022 Results SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-023 y and ovf SHALL remain stable while out_valid && !out_ready.
REQ-024 When out_valid=0, y and ovf SHALL hold their last values.
REQ-025 Simultaneous output consumption and input acceptance in the same cycle SHALL be supported at full throughput (one beat per cycle).
REQ-026 op=1 with a==b SHALL give y=0, ovf=0.
REQ-027 Add with a+b = 2^W SHALL give y=0, ovf=1 when SAT_EN is not defined.

Reset
REQ-028 While rst_n=0: all stage valids, out_valid, y and ovf SHALL be 0; in_ready SHALL be 1.
REQ-029 Assertion of rst_n mid-operation SHALL immediately discard all in-flight beats, with no result emitted for them after release.
REQ-030 The first edge after rst_n deasserts SHALL be able to accept a beat.

Configuration
REQ-031 Macro PIPE_ADDSUB_SAT_EN defined: saturate the result.
- Add with carry: y = all-ones.
- Subtract with borrow: y = 0.
- ovf is still reported as in REQ-021.
REQ-032 Macro PIPE_ADDSUB_SAT_EN undefined: y wraps modulo 2^W as in REQ-021.
REQ-033 Latency and handshake behaviour SHALL be identical with and without the macro.

Verification (W=12, STAGES=2 unless noted)
REQ-034 Reset, then a=0x100, b=0x023, op=0, one beat, out_ready=1 -> out_valid=1 two edges after acceptance, y=0x123, ovf=0.
REQ-035 a=0xFFF, b=0x001, op=0 -> y=0x000, ovf=1 without macro; y=0xFFF, ovf=1 with PIPE_ADDSUB_SAT_EN.
REQ-036 a=0x005, b=0x007, op=1 -> y=0xFFE, ovf=1 without macro; y=0x000, ovf=1 with macro. Also a=b=0x7A5, op=1 -> y=0, ovf=0.
REQ-037 Stream 10 back-to-back beats (a=i, b=1, op=0) with out_ready=0 for cycles 3..6 -> in_ready=0 while stalled, y stable while stalled, outputs 1..10 in order, no gaps beyond the stall.
REQ-038 Issue 3 beats, then pull rst_n low for one cycle before they emerge -> out_valid stays 0 and nothing is emitted for them.
REQ-039 STAGES=1 and STAGES=8, random beats with random out_ready -> scoreboard match, latency equal to STAGES when unstalled.
